// File: rtl/rr_lock_arbiter_if.sv
// rr_lock_arbiter_if
// Bundles the request/grant handshake between NUM_PORTS requesters and the
// round-robin lock arbiter.
//
// Signals:
//   req_i        requester -> arbiter  NUM_PORTS  level-sensitive requests
//   done_i       requester -> arbiter  1          current owner finished
//   gnt_o        arbiter -> requester  NUM_PORTS  one-hot grant, zero when idle
//   gnt_valid_o  arbiter -> requester  1          high while a grant is held
//   gnt_id_o     arbiter -> requester  ID_W       binary index of the owner
//   timeout_o    arbiter -> requester  1          pulse on forced release
//
// Modports:
//   master  requester side (drives req_i/done_i)
//   slave   arbiter side (drives the grant outputs)
interface rr_lock_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  localparam int ID_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_i;
  logic                 done_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic                 gnt_valid_o;
  logic [ID_W-1:0]      gnt_id_o;
  logic                 timeout_o;

  modport master (
    output req_i,
    output done_i,
    input  gnt_o,
    input  gnt_valid_o,
    input  gnt_id_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  done_i,
    output gnt_o,
    output gnt_valid_o,
    output gnt_id_o,
    output timeout_o
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
// Round-robin arbiter that locks the shared resource to one requester until
// that requester signals done_i or drops its request. Every release moves the
// priority pointer just past the previous owner, and one idle cycle always
// separates two grants.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    rr_lock_arbiter_if.slave (req_i, done_i in; gnt_o, gnt_valid_o,
//          gnt_id_o, timeout_o out, all outputs registered)
//
// Optional feature:
//   RR_LOCK_ARBITER_TIMEOUT_EN  when defined, a grant held for MAX_HOLD cycles
//                               without release is forcibly released and
//                               timeout_o pulses for that one cycle. When not
//                               defined, grants are held indefinitely and
//                               timeout_o is tied low.
module rr_lock_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 16
) (
  input logic              clk,
  input logic              reset,
  rr_lock_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_PORTS);

  // Sized copies of the port count so the wrap arithmetic stays width-clean.
  localparam logic [ID_W:0]   NUM_P   = (ID_W+1)'(NUM_PORTS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PORTS - 1);

  if (NUM_PORTS < 2 || NUM_PORTS > 32 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_lock_arbiter: NUM_PORTS must be 2..32 and MAX_HOLD >= 2");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;

  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W:0]   cand;
  logic            owner_release;
  logic            force_release;
  logic [ID_W-1:0] next_ptr;

  // Rotating priority search: walk ptr, ptr+1, ... wrapping at NUM_PORTS and
  // keep the first port that is requesting.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= NUM_P) begin
        cand = cand - NUM_P;
      end
      if (!found && bus.req_i[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  // The owner gives the resource back either explicitly or by dropping its
  // request; both look the same to the rest of the logic.
  always_comb begin
    owner_release = bus.done_i || !bus.req_i[bus.gnt_id_o];
    next_ptr      = (bus.gnt_id_o == LAST_ID) ? '0 : bus.gnt_id_o + ID_W'(1);
  end

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
  localparam int                HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [HC_W-1:0]   HOLD_MAX  = HC_W'(MAX_HOLD);

  logic [HC_W-1:0] hold_cnt;

  // A forced release only happens when the owner has not released on the same
  // edge, so a coincident done_i is treated as a normal release.
  always_comb begin
    force_release = !owner_release && (hold_cnt == HOLD_LAST);
  end
`else
  always_comb begin
    force_release = 1'b0;
  end

  assign bus.timeout_o = 1'b0;
`endif

  // Single FSM: IDLE arbitrates and grants on the next edge; BUSY holds the
  // grant until a release, then clears everything and advances ptr past the
  // owner so the next IDLE cycle re-arbitrates with rotated priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      bus.gnt_o       <= '0;
      bus.gnt_valid_o <= 1'b0;
      bus.gnt_id_o    <= '0;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
      hold_cnt        <= '0;
      bus.timeout_o   <= 1'b0;
`endif
    end else begin
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
      bus.timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            state           <= BUSY;
            bus.gnt_o       <= NUM_PORTS'(1) << winner;
            bus.gnt_valid_o <= 1'b1;
            bus.gnt_id_o    <= winner;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
            hold_cnt        <= '0;
`endif
          end
        end
        BUSY: begin
          if (owner_release || force_release) begin
            state           <= IDLE;
            ptr             <= next_ptr;
            bus.gnt_o       <= '0;
            bus.gnt_valid_o <= 1'b0;
            bus.gnt_id_o    <= '0;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
            bus.timeout_o   <= force_release;
`endif
          end
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
          else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
